// File: rtl/out_mux_pkg.sv
// Shared defaults and channel numbering for the decryptor output path.
package out_mux_pkg;

  localparam int DEF_D_WIDTH = 8;
  localparam int DEF_N_CH    = 3;
  localparam int DEF_SEL_W   = 2;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    CH_CAESAR  = 2'd0,
    CH_SCYTALE = 2'd1,
    CH_ZIGZAG  = 2'd2
  } ch_e;

  // Pointer width: one extra wrap bit to tell full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is taken
// when a pop happens in the same cycle.
module sync_fifo
  import out_mux_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int D_WIDTH = DEF_D_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [D_WIDTH-1:0]       wdata,
  output logic [D_WIDTH-1:0]       rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [D_WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]      wr_ptr_r;
  logic [PW-1:0]      rd_ptr_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign level = wr_ptr_r - rd_ptr_r;
  assign rdata = mem_r[rd_ptr_r[AW-1:0]];

  // Qualify requests against the current occupancy.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Storage; stale contents are never visible because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/out_mux_fifo.sv
// Buffered decryptor output mux: selects one channel's byte stream into a
// FIFO, presents it with ready/valid and counts bytes lost to overflow.
module out_mux_fifo
  import out_mux_pkg::*;
#(
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int N_CH    = DEF_N_CH,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SEL_W-1:0]          select,
  input  logic [N_CH*D_WIDTH-1:0]   data_i,
  input  logic [N_CH-1:0]           valid_i,
  input  logic                      clr_i,
  output logic [D_WIDTH-1:0]        data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [$clog2(DEPTH):0]    level_o,
  output logic                      overflow_o,
  output logic [CNT_W-1:0]          drop_cnt_o
);

  logic                     sel_valid_s;
  logic [D_WIDTH-1:0]       sel_data_s;
  logic                     pop_s;
  logic                     push_s;
  logic                     drop_s;
  logic                     full_s;
  logic                     empty_s;
  logic [D_WIDTH-1:0]       fifo_data_s;
  logic [$clog2(DEPTH):0]   level_s;
  logic                     overflow_r;
  logic [CNT_W-1:0]         drop_cnt_r;

  // Channel decode; a select outside 0..N_CH-1 matches nothing and never captures.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_valid_s = sel_valid_s | ((select == SEL_W'(k)) & valid_i[k]);
      sel_data_s  = sel_data_s |
                    ({D_WIDTH{select == SEL_W'(k)}} & data_i[k*D_WIDTH +: D_WIDTH]);
    end
  end

  // Handshake and capture/drop decisions.
  always_comb begin
    pop_s  = !empty_s && ready_i;
    push_s = sel_valid_s && (!full_s || pop_s);
    drop_s = sel_valid_s && full_s && !pop_s;
  end

  sync_fifo #(
    .DEPTH   (DEPTH),
    .D_WIDTH (D_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (sel_data_s),
    .rdata (fifo_data_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  // Drop accounting; clear beats a coincident drop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end else if (clr_i) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= '0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != {CNT_W{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + CNT_W'(1);
      end
    end
  end

  assign data_o     = empty_s ? {D_WIDTH{1'b0}} : fifo_data_s;
  assign valid_o    = !empty_s;
  assign level_o    = level_s;
  assign overflow_o = overflow_r;
  assign drop_cnt_o = drop_cnt_r;

endmodule

// File: tb/tb_out_mux_fifo.sv
// Scoreboard bench for out_mux_fifo: a queue model predicts occupancy, drops
// and byte order; a negedge monitor checks every presented output.
module tb_out_mux_fifo;
  import out_mux_pkg::*;

  localparam int MDEPTH = 4;
  localparam int MAXCNT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  select;
  logic [23:0] data_i;
  logic [2:0]  valid_i;
  logic        clr_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [2:0]  level_o;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;

  out_mux_fifo dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .select     (select),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .clr_i      (clr_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .level_o    (level_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  bit         chk_en = 1'b0;
  logic [7:0] mq[$];
  logic [7:0] sb_q[$];
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [23:0] pk(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    return {c2, c1, c0};
  endfunction

  // Reference behaviour for one clock edge, from the pre-edge model state.
  task automatic model_apply(input logic [1:0] s, input logic [23:0] d, input logic [2:0] v,
                             input logic r, input logic c, input logic rn);
    bit         pop, cap, acc;
    logic [7:0] b;
    if (!rn) begin
      mq.delete();
      sb_q.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
      chk_en = 1'b1;
    end else begin
      pop = (mq.size() > 0) && r;
      cap = (s < 3) && v[s];
      b   = 8'(d >> (8 * s));
      acc = cap && ((mq.size() - (pop ? 1 : 0)) < MDEPTH);
      if (pop) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(b);
        sb_q.push_back(b);
      end
      if (c) begin
        m_ovf = 1'b0;
        m_cnt = 0;
      end else if (cap && !acc) begin
        m_ovf = 1'b1;
        if (m_cnt < MAXCNT) m_cnt++;
      end
    end
  endtask

  task automatic step(input logic [1:0] s, input logic [23:0] d, input logic [2:0] v,
                      input logic r, input logic c, input logic rn);
    select = s; data_i = d; valid_i = v; ready_i = r; clr_i = c; rst_n = rn;
    @(posedge clk);
    model_apply(s, d, v, r, c, rn);
    #1;
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", 32'(level_o), 32'(mq.size()));
      chk("valid", 32'(valid_o), 32'(mq.size() != 0));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      chk("drop_cnt", 32'(drop_cnt_o), 32'(m_cnt));
      if (valid_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_byte", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          chk("data", 32'(data_o), 32'(sb_q[0]));
          if (ready_i) void'(sb_q.pop_front());
        end
      end else begin
        chk("data_empty", 32'(data_o), 32'h0);
      end
    end
  end

  initial begin
    step(2'd0, 24'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    step(2'd0, 24'h0, 3'b000, 1'b0, 1'b0, 1'b0);
    // single byte, one-cycle latency
    step(CH_SCYTALE, pk(8'h00, 8'h41, 8'h00), 3'b010, 1'b1, 1'b0, 1'b1);
    step(2'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b1);
    step(2'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b1);
    // fill under backpressure, then overflow by three, then clear
    for (int i = 0; i < 7; i++)
      step(CH_CAESAR, pk(8'(8'h10 + i), 8'hEE, 8'hDD), 3'b111, 1'b0, 1'b0, 1'b1);
    step(2'd0, 24'h0, 3'b000, 1'b0, 1'b1, 1'b1);
    // full FIFO: capture together with pop
    step(CH_CAESAR, pk(8'h55, 8'h00, 8'h00), 3'b001, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(2'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b1);
    // select rules and mid-stream switch
    step(2'd3, pk(8'hA1, 8'hA2, 8'hA3), 3'b111, 1'b0, 1'b0, 1'b1);
    step(CH_ZIGZAG, pk(8'hB1, 8'hB2, 8'hB3), 3'b001, 1'b0, 1'b0, 1'b1);
    step(CH_CAESAR, pk(8'h20, 8'h00, 8'h90), 3'b101, 1'b0, 1'b0, 1'b1);
    step(CH_CAESAR, pk(8'h21, 8'h00, 8'h91), 3'b101, 1'b0, 1'b0, 1'b1);
    step(CH_ZIGZAG, pk(8'h22, 8'h00, 8'h30), 3'b101, 1'b0, 1'b0, 1'b1);
    step(CH_ZIGZAG, pk(8'h23, 8'h00, 8'h31), 3'b101, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(2'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b1);
    // level 3 with overflow set, then mid-stream reset and fresh capture
    for (int i = 0; i < 5; i++)
      step(CH_SCYTALE, pk(8'h00, 8'(8'h60 + i), 8'h00), 3'b010, 1'b0, 1'b0, 1'b1);
    step(2'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b1);
    step(CH_SCYTALE, pk(8'h00, 8'h77, 8'h00), 3'b010, 1'b1, 1'b1, 1'b0);
    step(CH_ZIGZAG, pk(8'h00, 8'h00, 8'h5A), 3'b100, 1'b0, 1'b0, 1'b1);
    step(2'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b1);
    // drop counter saturation
    for (int i = 0; i < 265; i++)
      step(CH_CAESAR, pk(8'(i), 8'h00, 8'h00), 3'b001, 1'b0, 1'b0, 1'b1);
    step(2'd0, 24'h0, 3'b000, 1'b1, 1'b1, 1'b1);
    // randomized traffic
    for (int i = 0; i < 2000; i++)
      step(2'($urandom_range(0, 3)), 24'($urandom), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 149) != 0));
    for (int i = 0; i < 6; i++) step(2'd0, 24'h0, 3'b000, 1'b1, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/out_mux_fifo.md
# out_mux_fifo

Parametrised, buffered successor to the decryptor output mux. It routes the byte stream of one of N_CH decryptor channels, chosen by `select`, into a DEPTH-entry FIFO, and presents it to the system output with a ready/valid handshake. It adds downstream backpressure, lossless buffering of back-to-back input bytes, and overflow accounting. It sits between the decryptor bank (Caesar, Scytale, ZigZag, ...) and the system output port.

## Interface
- `D_WIDTH`, 8: data byte width.
- `N_CH`, 3: number of decryptor channels, minimum 2.
- `SEL_W`, 2: `select` width; must satisfy 2^SEL_W >= N_CH.
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `CNT_W`, 8: drop counter width.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `select`, input, SEL_W: channel index; values >= N_CH are invalid.
- `data_i`, input, N_CH*D_WIDTH: flat channel data; channel k is `data_i[k*D_WIDTH +: D_WIDTH]`.
- `valid_i`, input, N_CH: per-channel byte strobe.
- `clr_i`, input, 1: synchronous clear of `overflow_o` and `drop_cnt_o` only.
- `data_o`, output, D_WIDTH: FIFO head byte.
- `valid_o`, output, 1: FIFO not empty.
- `ready_i`, input, 1: downstream accepts the byte.
- `level_o`, output, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow_o`, output, 1: sticky flag; at least one byte was dropped.
- `drop_cnt_o`, output, CNT_W: saturating count of dropped bytes.

## Operation
- **Capture condition:** `cap = (select < N_CH) && valid_i[select]`, sampled at posedge. Invalid `select` never captures, and valid bits of unselected channels are ignored.
- **Pop:** `pop = valid_o && ready_i`. The head advances one entry per pop.
- **Push:** on `cap`, the selected byte is written if `level < DEPTH`, or if `level == DEPTH && pop` in the same cycle. The full-with-pop case is a simultaneous push and pop; level stays DEPTH and nothing is lost.
- **Drop:** on `cap` with a full FIFO and no pop, the byte is discarded.
  - `overflow_o` is set.
  - `drop_cnt_o` increments and saturates at 2^CNT_W-1.
- **Clear:** `clr_i` clears `overflow_o` and `drop_cnt_o` to 0. If `clr_i` coincides with a drop, the clear wins and the count stays 0. FIFO contents are untouched.
- **Pointers:** `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits wide and wrap naturally.
  - `level = wr_ptr - rd_ptr`.
  - Empty when the pointers are equal.
  - Full when the MSBs differ and the rest are equal.
- **Output data:** `data_o` = mem[rd_ptr] while non-empty, 0 when empty.
- **Stability:** `data_o` holds stable while `valid_o && !ready_i`.
- **Mid-stream select change:** takes effect on the next capture. Bytes already buffered drain in order.
- **Reset (`rst_n` low at posedge):** pointers 0, `data_o` 0, `valid_o` 0, `level_o` 0, `overflow_o` 0, `drop_cnt_o` 0. Reset dominates push, pop and `clr_i`. Mid-stream reset discards all buffered bytes, and no partial state survives.

## Timing
- **Latency:** a byte captured at edge t appears on `data_o` with `valid_o` high after edge t, provided the FIFO was empty. Latency is one cycle, the same as the previous mux.
- **Throughput:** one push and one pop per cycle sustained. With `ready_i` held high, a continuous `valid_i` stream passes with no drops and no bubbles.
- **Output timing:** `valid_o`, `level_o`, `overflow_o` and `drop_cnt_o` are all derived from registers only, with no combinational path from inputs.
- **Pop timing:** a pop at edge t exposes the next entry, or empty, immediately after t.

## Structure
- **Shared package `out_mux_pkg`:**
  - default parameters `D_WIDTH`, `N_CH`, `DEPTH`;
  - channel index constants `CH_CAESAR=0`, `CH_SCYTALE=1`, `CH_ZIGZAG=2`.
- **Sub-module `sync_fifo`** (DEPTH, D_WIDTH): push/pop/full/empty/level, with simultaneous push and pop when full.
- **`out_mux_fifo` top:** select decode, capture, drop accounting, and output gating to 0 when empty.

## Test plan
- **Single byte:** select=1, data ch1=0x41 with `valid_i`=3'b010 for one cycle, `ready_i`=1 → next cycle `data_o`=0x41, `valid_o`=1 for one cycle. Then `data_o`=0, `level_o`=0.
- **Backpressure, no loss:** `ready_i`=0, push 0x10,0x11,0x12,0x13 on ch0 (DEPTH=4) → `level_o`=4, `data_o` holds 0x10. Raise `ready_i` → 0x10..0x13 come out in order over 4 cycles, `overflow_o`=0.
- **Overflow:** FIFO full with `ready_i`=0, push 3 more bytes → `drop_cnt_o`=3, `overflow_o`=1, contents unchanged. Assert `clr_i` → both 0, `level_o` still 4.
- **Full push+pop:** full FIFO, `ready_i`=1 and a capture in the same cycle → `level_o` stays 4, no drop, new byte appears last.
- **Select rules:** select=3 with `valid_i`=3'b111 → no push. select=2 with only `valid_i[0]` high → no push. Switch select 0→2 mid-stream → buffered ch0 bytes precede ch2 bytes.
- **Reset mid-stream:** `level_o`=3 and `overflow_o`=1, pull `rst_n` low for one edge → all outputs 0. The next capture yields 1-cycle latency again.
